symbol_modulator: RTL

SYMBOL_MODULATOR -- requirements
Module: symbol_modulator

---
 rtl/symbol_modulator.sv | 99 +++++++++
 1 files changed

// File: rtl/symbol_modulator.sv
// symbol_modulator: symbol timer + 5-bit PN source driving BPSK and on-off ASK
// modulation of an offset-binary carrier stream.
// Optional feature: define MODULATOR_SYMBOL_COUNT_EN to add a 16-bit
// free-running count of symbol boundaries on output sym_count.
module symbol_modulator #(
   parameter int S     = 12,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] sym_div,
   input  logic [S-1:0]     carrier,
   input  logic             carrier_valid,
   output logic [S-1:0]     bpsk_out,
   output logic [S-1:0]     ask_out,
   output logic             out_valid,
   output logic             data_bit,
   output logic             sym_tick
`ifdef MODULATOR_SYMBOL_COUNT_EN
   ,
   output logic [15:0]      sym_count
`endif
);

   // Offset-binary zero level.
   localparam logic [S-1:0] MID = {1'b1, {(S-1){1'b0}}};

   logic [DIV_W-1:0] r_count;
   logic [4:0]       r_lfsr;
   logic             r_tick;
   logic [S-1:0]     r_bpsk;
   logic [S-1:0]     r_ask;
   logic             r_vld;
   logic             w_boundary;
   logic             w_fb;
   logic             w_bit;

   // A boundary uses >= so shrinking sym_div below the running count
   // ends the symbol on the next enabled cycle instead of wrapping around.
   assign w_boundary = enable && (r_count >= sym_div);
   assign w_fb       = r_lfsr[4] ^ r_lfsr[2];
   assign w_bit      = r_lfsr[0];

   // Symbol period counter; frozen while enable is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (enable) begin
         if (w_boundary) r_count <= '0;
         else            r_count <= r_count + 1'b1;
      end
   end

   // PN data source (x^5+x^3+1) advancing once per symbol; tick follows one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr <= 5'b00001;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_boundary;
         if (w_boundary) r_lfsr <= {r_lfsr[3:0], w_fb};
      end
   end

   // Modulators run regardless of enable and use the pre-update data bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bpsk <= MID;
         r_ask  <= MID;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= carrier_valid;
         if (carrier_valid) begin
            r_bpsk <= w_bit ? carrier : ~carrier;
            r_ask  <= w_bit ? carrier : MID;
         end
      end
   end

`ifdef MODULATOR_SYMBOL_COUNT_EN
   logic [15:0] r_sym_count;

   // Boundary counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_sym_count <= '0;
      else if (w_boundary) r_sym_count <= r_sym_count + 16'd1;
   end

   assign sym_count = r_sym_count;
`endif

   assign bpsk_out  = r_bpsk;
   assign ask_out   = r_ask;
   assign out_valid = r_vld;
   assign data_bit  = w_bit;
   assign sym_tick  = r_tick;

endmodule
